// File: rtl/sigmod_pkg.sv
// Shared constants and types for the signal modulator family: default LFSR
// shape, symbol timing divider and symbol-bit type.
package sigmod_pkg;

  localparam int         LFSR_N    = 7;
  localparam logic [6:0] LFSR_TAPS = 7'b1100000;
  localparam logic [6:0] LFSR_SEED = 7'b0000001;

  // Also sets the modulator's phase-step timing, so keep the two in step.
  localparam int SYM_DIV = 256;
  localparam int SYM_CW  = 16;

  typedef logic sym_bit_t;

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR with lock-up guard; steps on request, reloads with a
// zero-safe value and exposes the next-step and reload values.
module lfsr_core
  import sigmod_pkg::*;
#(
  parameter int         N    = LFSR_N,
  parameter logic [N-1:0] TAPS = N'(LFSR_TAPS),
  parameter logic [N-1:0] SEED = N'(LFSR_SEED)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic         reload,
  input  logic [N-1:0] reload_val,
  output logic [N-1:0] state_next,
  output logic [N-1:0] reload_state
);

  logic [N-1:0] state;
  logic [N-1:0] shifted;
  logic         fb;

  // Feedback, shift and the all-zero escape for both step and reload values
  always_comb begin
    fb      = ^(state & TAPS);
    shifted = {state[N-2:0], fb};
    if (shifted == '0) begin
      state_next = SEED;
    end else begin
      state_next = shifted;
    end
    if (reload_val == '0) begin
      reload_state = SEED;
    end else begin
      reload_state = reload_val;
    end
  end

  // State register: reset beats reload beats step
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else if (reload) begin
      state <= reload_state;
    end else if (step) begin
      state <= state_next;
    end else begin
      state <= state;
    end
  end

endmodule

// File: rtl/pn_symbol_source.sv
// Pseudo-random symbol source: one LFSR step every DIV enabled clocks, with a
// held data bit, a symbol strobe, a period-start marker and a symbol counter.
module pn_symbol_source
  import sigmod_pkg::*;
#(
  parameter int           N    = LFSR_N,
  parameter logic [N-1:0] TAPS = N'(LFSR_TAPS),
  parameter logic [N-1:0] SEED = N'(LFSR_SEED),
  parameter int           DIV  = SYM_DIV,
  parameter int           CW   = SYM_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          seed_ld,
  input  logic [N-1:0]  seed_in,
  output logic          m,
  output logic          sym_strobe,
  output logic          load,
  output logic [CW-1:0] sym_cnt
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [N-1:0]  state_next;
  logic [N-1:0]  reload_state;

  assign tick = en && (div_cnt == DW'(DIV - 1));

  lfsr_core #(
    .N    (N),
    .TAPS (TAPS),
    .SEED (SEED)
  ) u_lfsr (
    .clk          (clk),
    .rst          (rst),
    .step         (tick),
    .reload       (seed_ld),
    .reload_val   (seed_in),
    .state_next   (state_next),
    .reload_state (reload_state)
  );

  // Symbol divider; a reload restarts the symbol so the next tick is DIV enabled cycles away
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (seed_ld) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= div_cnt + DW'(1);
    end else begin
      div_cnt <= div_cnt;
    end
  end

  // Output registers, one clock after the tick that advances the LFSR
  always_ff @(posedge clk) begin
    if (rst) begin
      m          <= 1'b0;
      sym_strobe <= 1'b0;
      load       <= 1'b0;
      sym_cnt    <= '0;
    end else if (seed_ld) begin
      m          <= reload_state[N-1];
      sym_strobe <= 1'b0;
      load       <= 1'b0;
      sym_cnt    <= '0;
    end else if (tick) begin
      m          <= state_next[N-1];
      sym_strobe <= 1'b1;
      load       <= (state_next == SEED);
      if (state_next == SEED) begin
        sym_cnt <= '0;
      end else begin
        sym_cnt <= sym_cnt + CW'(1);
      end
    end else begin
      m          <= m;
      sym_strobe <= 1'b0;
      load       <= 1'b0;
      sym_cnt    <= sym_cnt;
    end
  end

endmodule

// File: tb/tb_pn_symbol_source.sv
// Directed bench for pn_symbol_source with DIV=4 and the default 7-bit LFSR,
// checked against hand values and a small reference LFSR model.
module tb_pn_symbol_source;

  localparam int         DIV  = 4;
  localparam logic [6:0] SEED = 7'b0000001;
  localparam logic [6:0] TAPS = 7'b1100000;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        seed_ld;
  logic [6:0]  seed_in;
  logic        m;
  logic        sym_strobe;
  logic        load;
  logic [15:0] sym_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [6:0]  ms;
  logic [15:0] mcnt;
  logic        exp_m;
  logic        exp_load;
  logic        hand [1:7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  pn_symbol_source #(
    .N    (7),
    .TAPS (TAPS),
    .SEED (SEED),
    .DIV  (DIV),
    .CW   (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .seed_ld    (seed_ld),
    .seed_in    (seed_in),
    .m          (m),
    .sym_strobe (sym_strobe),
    .load       (load),
    .sym_cnt    (sym_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic model_step();
    logic       fb;
    logic [6:0] nx;
    fb = ^(ms & TAPS);
    nx = {ms[5:0], fb};
    if (nx == 7'd0) nx = SEED;
    ms       = nx;
    exp_m    = nx[6];
    exp_load = (nx == SEED);
    mcnt     = exp_load ? 16'd0 : mcnt + 16'd1;
  endtask

  // Advance until a strobe appears (bounded), flagging any load without strobe
  task automatic wait_strobe(output int edges);
    edges = 0;
    do begin
      tick_edge();
      edges++;
      n_cmp++;
      if (load && !sym_strobe) begin
        n_fail++;
        $display("FAIL load_alone: load=%0b sym_strobe=%0b want load only with strobe", load, sym_strobe);
      end
    end while (!sym_strobe && edges < 4 * DIV);
    n_cmp++;
    if (sym_strobe !== 1'b1) begin
      n_fail++;
      $display("FAIL strobe_timeout: no strobe within %0d cycles", edges);
    end
  endtask

  task automatic check_symbol(input string tag);
    n_cmp++;
    if (m !== exp_m) begin
      n_fail++;
      $display("FAIL %s_m: got %0b want %0b", tag, m, exp_m);
    end
    n_cmp++;
    if (load !== exp_load) begin
      n_fail++;
      $display("FAIL %s_load: got %0b want %0b", tag, load, exp_load);
    end
    n_cmp++;
    if (sym_cnt !== mcnt) begin
      n_fail++;
      $display("FAIL %s_cnt: got %0d want %0d", tag, sym_cnt, mcnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; seed_ld = 1'b0; seed_in = 7'd0;
    tick_edge();
    tick_edge();
    n_cmp++;
    if ({m, sym_strobe, load, sym_cnt} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %0h want 0", {m, sym_strobe, load, sym_cnt});
    end
    rst = 1'b0;
    en  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick_edge();
      n_cmp++;
      if ({m, sym_strobe} !== 2'b00) begin
        n_fail++;
        $display("FAIL first_quiet: cycle %0d m/strobe=%b want 00", i, {m, sym_strobe});
      end
    end
    tick_edge();
    n_cmp++;
    if (sym_strobe !== 1'b1) begin
      n_fail++;
      $display("FAIL first_strobe: got %0b want 1", sym_strobe);
    end
    ms = SEED; mcnt = 16'd0;
    model_step();
    check_symbol("strobe1");
    n_cmp++;
    if (m !== hand[1]) begin
      n_fail++;
      $display("FAIL hand_m1: got %0b want %0b", m, hand[1]);
    end
  endtask

  task automatic test_sequence();
    int edges;
    int loads_seen;
    loads_seen = 0;
    for (int k = 2; k <= 127; k++) begin
      if (k == 127) begin
        n_cmp++;
        if (sym_cnt !== 16'd126) begin
          n_fail++;
          $display("FAIL cnt_before_wrap: got %0d want 126", sym_cnt);
        end
      end
      wait_strobe(edges);
      n_cmp++;
      if (edges != DIV) begin
        n_fail++;
        $display("FAIL strobe_spacing: strobe %0d after %0d cycles want %0d", k, edges, DIV);
      end
      model_step();
      check_symbol("seq");
      if (k <= 7) begin
        n_cmp++;
        if (m !== hand[k]) begin
          n_fail++;
          $display("FAIL hand_m%0d: got %0b want %0b", k, m, hand[k]);
        end
      end
      if (load) loads_seen++;
    end
    n_cmp++;
    if ({load, sym_cnt} !== {1'b1, 16'd0}) begin
      n_fail++;
      $display("FAIL period_marker: load=%0b cnt=%0d want load=1 cnt=0", load, sym_cnt);
    end
    n_cmp++;
    if (loads_seen != 1) begin
      n_fail++;
      $display("FAIL load_count: got %0d want 1", loads_seen);
    end
  endtask

  task automatic test_enable_freeze();
    tick_edge();
    tick_edge();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick_edge();
      n_cmp++;
      if ({sym_strobe, m, sym_cnt} !== {1'b0, exp_m, mcnt}) begin
        n_fail++;
        $display("FAIL freeze_hold: strobe=%0b m=%0b cnt=%0d want 0/%0b/%0d", sym_strobe, m, sym_cnt, exp_m, mcnt);
      end
    end
    en = 1'b1;
    tick_edge();
    n_cmp++;
    if (sym_strobe !== 1'b0) begin
      n_fail++;
      $display("FAIL freeze_early: got %0b want 0", sym_strobe);
    end
    tick_edge();
    n_cmp++;
    if (sym_strobe !== 1'b1) begin
      n_fail++;
      $display("FAIL freeze_resume: got %0b want 1", sym_strobe);
    end
    model_step();
    check_symbol("resume");
  endtask

  task automatic test_seed_reload();
    int edges;
    for (int i = 0; i < 3; i++) tick_edge();
    seed_ld = 1'b1; seed_in = 7'h40;
    tick_edge();
    seed_ld = 1'b0;
    n_cmp++;
    if ({m, sym_strobe, load, sym_cnt} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL reload_40: m=%0b strobe=%0b load=%0b cnt=%0d want 1/0/0/0", m, sym_strobe, load, sym_cnt);
    end
    ms = 7'h40; mcnt = 16'd0;
    wait_strobe(edges);
    n_cmp++;
    if (edges != DIV) begin
      n_fail++;
      $display("FAIL reload_spacing: got %0d want %0d", edges, DIV);
    end
    model_step();
    check_symbol("after40");
    seed_ld = 1'b1; seed_in = 7'd0;
    tick_edge();
    seed_ld = 1'b0;
    n_cmp++;
    if ({m, sym_strobe, load, sym_cnt} !== 19'd0) begin
      n_fail++;
      $display("FAIL reload_zero: m=%0b strobe=%0b load=%0b cnt=%0d want all 0", m, sym_strobe, load, sym_cnt);
    end
    ms = SEED; mcnt = 16'd0;
    wait_strobe(edges);
    n_cmp++;
    if (edges != DIV) begin
      n_fail++;
      $display("FAIL reload_zero_spacing: got %0d want %0d", edges, DIV);
    end
    model_step();
    check_symbol("afterzero");
  endtask

  task automatic test_reset_mid();
    int edges;
    while (mcnt < 16'd49) begin
      wait_strobe(edges);
      model_step();
      check_symbol("pre_rst");
    end
    tick_edge();
    rst = 1'b1;
    tick_edge();
    rst = 1'b0;
    n_cmp++;
    if ({m, sym_strobe, load, sym_cnt} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_mid: m=%0b strobe=%0b load=%0b cnt=%0d want all 0", m, sym_strobe, load, sym_cnt);
    end
    ms = SEED; mcnt = 16'd0;
    for (int k = 1; k <= 10; k++) begin
      wait_strobe(edges);
      n_cmp++;
      if (edges != DIV) begin
        n_fail++;
        $display("FAIL restart_spacing: strobe %0d after %0d want %0d", k, edges, DIV);
      end
      model_step();
      check_symbol("restart");
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_enable_freeze();
    test_seed_reload();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
